// File: rtl/binary_onehot_pkg.sv
// ----------------------------------------------------------------------------
// binary_onehot_pkg
//   Shared types and decode helper for the binary-to-one-hot pipeline.
//   - skid_state_e : occupancy of the 2-entry skid buffer (EMPTY/ONE/FULL)
//   - DEF_*        : default widths used by binary_onehot_pipe
//   - MAX_IDX      : highest legal index for the default result width
//   - onehot_f     : per-bit decode of an index into one-hot / thermometer
//   Optional thermometer mode is enabled by BINARY_ONEHOT_THERM_EN in the top.
// ----------------------------------------------------------------------------
package binary_onehot_pkg;

    localparam int DEF_DAT_WID     = 4;
    localparam int DEF_RESULT_WID  = 16;
    localparam int DEF_ERR_CNT_WID = 8;
    localparam int MAX_IDX         = DEF_RESULT_WID - 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Value of result bit 'pos' for index 'idx'. Out-of-range indices never
    // wrap: one-hot gives all zeros, thermometer gives all ones.
    function automatic logic onehot_f(input logic [31:0] idx,
                                      input logic        therm,
                                      input int unsigned pos,
                                      input int unsigned result_wid);
        logic bit_val;
        if (idx >= result_wid) begin
            bit_val = therm;
        end else if (therm) begin
            bit_val = (pos <= idx);
        end else begin
            bit_val = (pos == idx);
        end
        return bit_val;
    endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// ----------------------------------------------------------------------------
// onehot_skid_buf
//   Generic 2-entry skid buffer with a fully registered in_ready.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   upstream handshake (in_ready is a flop)
//     in_data [PAY_W]     payload accepted on in_valid & in_ready
//     out_valid/out_ready downstream handshake (out_valid = main full)
//     out_data [PAY_W]    payload held in the main (output) register
// ----------------------------------------------------------------------------
module onehot_skid_buf
    import binary_onehot_pkg::*;
#(
    parameter int PAY_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAY_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PAY_W-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [PAY_W-1:0] main_q, main_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = (state_q != ST_EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (accept && pop) begin
                    main_d  = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Look-ahead so in_ready comes straight from a flop
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/binary_onehot_pipe.sv
// ----------------------------------------------------------------------------
// binary_onehot_pipe
//   Pipelined binary-to-one-hot decoder with valid/ready flow control.
//   Decode and the error counter are combinational ahead of a 2-entry skid
//   buffer; the stored payload is {err, result}.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     input handshake (in_ready registered)
//     in_dat [DAT_WID]      binary index
//     in_therm              thermometer select (BINARY_ONEHOT_THERM_EN only)
//     out_valid/out_ready   output handshake
//     out_result[RESULT_WID] decoded vector
//     out_err               beat's index was out of range
//     err_cnt[ERR_CNT_WID]  saturating count of accepted out-of-range beats
//     err_clr               synchronous clear of err_cnt (wins over increment)
//   Build option: define BINARY_ONEHOT_THERM_EN to add in_therm.
// ----------------------------------------------------------------------------
module binary_onehot_pipe
    import binary_onehot_pkg::*;
#(
    parameter int DAT_WID     = DEF_DAT_WID,
    parameter int RESULT_WID  = DEF_RESULT_WID,
    parameter int ERR_CNT_WID = DEF_ERR_CNT_WID
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DAT_WID-1:0]     in_dat,
`ifdef BINARY_ONEHOT_THERM_EN
    input  logic                   in_therm,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RESULT_WID-1:0]  out_result,
    output logic                   out_err,
    output logic [ERR_CNT_WID-1:0] err_cnt,
    input  logic                   err_clr
);

    localparam int PAY_W = RESULT_WID + 1;

    logic                   therm_sel;
    logic [RESULT_WID-1:0]  dec_result;
    logic                   dec_err;
    logic [PAY_W-1:0]       out_pay;
    logic                   accept;
    logic [ERR_CNT_WID-1:0] err_cnt_q, err_cnt_d;

`ifdef BINARY_ONEHOT_THERM_EN
    // The mode is folded into the decoded vector, so it travels with the beat.
    assign therm_sel = in_therm;
`else
    assign therm_sel = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < RESULT_WID; gi++) begin : g_dec
            assign dec_result[gi] = onehot_f(32'(in_dat), therm_sel, gi, RESULT_WID);
        end
    endgenerate

    assign dec_err = (32'(in_dat) >= 32'(RESULT_WID));

    onehot_skid_buf #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_err, dec_result}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign out_result = out_pay[RESULT_WID-1:0];
    assign out_err    = out_pay[RESULT_WID];
    assign accept     = in_valid & in_ready;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (accept && dec_err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_binary_onehot_pipe.sv
// Directed bench: instance A uses the default 16-bit result, instance B a
// 10-bit result so out-of-range indices and the error counter can be driven.
module tb_binary_onehot_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic [3:0]  in_dat = '0;
`ifdef BINARY_ONEHOT_THERM_EN
    logic        in_therm = 1'b0;
`endif
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        in_ready_a, out_valid_a, out_err_a;
    logic [15:0] out_result_a;
    logic [7:0]  err_cnt_a;
    logic        in_ready_b, out_valid_b, out_err_b;
    logic [9:0]  out_result_b;
    logic [7:0]  err_cnt_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    binary_onehot_pipe #(.DAT_WID(4), .RESULT_WID(16), .ERR_CNT_WID(8)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .in_dat     (in_dat),
`ifdef BINARY_ONEHOT_THERM_EN
        .in_therm   (in_therm),
`endif
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_result (out_result_a),
        .out_err    (out_err_a),
        .err_cnt    (err_cnt_a),
        .err_clr    (err_clr)
    );

    binary_onehot_pipe #(.DAT_WID(4), .RESULT_WID(10), .ERR_CNT_WID(8)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .in_dat     (in_dat),
`ifdef BINARY_ONEHOT_THERM_EN
        .in_therm   (in_therm),
`endif
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_result (out_result_b),
        .out_err    (out_err_b),
        .err_cnt    (err_cnt_b),
        .err_clr    (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %s = 0x%0h", tag, got);
        end else begin
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_stream [16] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                                     16'h0010, 16'h0020, 16'h0040, 16'h0080,
                                     16'h0100, 16'h0200, 16'h0400, 16'h0800,
                                     16'h1000, 16'h2000, 16'h4000, 16'h8000};

    initial begin
        // ---- reset state ----
        step();
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_result", 32'(out_result_a), 32'd0);
        check("rst_out_err", 32'(out_err_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_err_cnt", 32'(err_cnt_b), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- single beat, index 5 ----
        out_ready  = 1'b1;
        in_valid_a = 1'b1;
        in_dat     = 4'd5;
        step();
        in_valid_a = 1'b0;
        check("beat5_valid", 32'(out_valid_a), 32'd1);
        check("beat5_result", 32'(out_result_a), 32'h0020);
        check("beat5_err", 32'(out_err_a), 32'd0);
        step();
        check("beat5_drained", 32'(out_valid_a), 32'd0);

        // ---- back-to-back stream 0..15 ----
        for (int i = 0; i < 16; i++) begin
            in_valid_a = 1'b1;
            in_dat     = 4'(i);
            step();
            check($sformatf("stream%0d_result", i), 32'(out_result_a), 32'(exp_stream[i]));
            check($sformatf("stream%0d_in_ready", i), 32'(in_ready_a), 32'd1);
        end
        in_valid_a = 1'b0;
        step();
        check("stream_drained", 32'(out_valid_a), 32'd0);

        // ---- RESULT_WID=10: range boundary and saturating counter ----
        in_valid_b = 1'b1;
        in_dat     = 4'd12;
        step();
        check("oor12_result", 32'(out_result_b), 32'd0);
        check("oor12_err", 32'(out_err_b), 32'd1);
        check("oor12_err_cnt", 32'(err_cnt_b), 32'd1);
        in_dat = 4'd9;
        step();
        check("idx9_result", 32'(out_result_b), 32'h0200);
        check("idx9_err", 32'(out_err_b), 32'd0);
        check("idx9_err_cnt", 32'(err_cnt_b), 32'd1);
        in_dat = 4'd10;
        step();
        check("idx10_result", 32'(out_result_b), 32'd0);
        check("idx10_err", 32'(out_err_b), 32'd1);
        check("idx10_err_cnt", 32'(err_cnt_b), 32'd2);
        in_dat = 4'd12;
        for (int i = 0; i < 253; i++) step();
        check("err_cnt_at_255", 32'(err_cnt_b), 32'd255);
        for (int i = 0; i < 45; i++) step();
        check("err_cnt_saturated", 32'(err_cnt_b), 32'd255);

        // clear in the same cycle as an error beat: clear wins
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_wins_err_cnt", 32'(err_cnt_b), 32'd0);
        check("clr_beat_err", 32'(out_err_b), 32'd1);
        step();
        check("after_clr_err_cnt", 32'(err_cnt_b), 32'd1);
        in_valid_b = 1'b0;
        step();

        // ---- backpressure: feed 3,7,9 with out_ready low ----
        out_ready  = 1'b0;
        in_valid_a = 1'b1;
        in_dat     = 4'd3;
        step();
        check("bp_first_result", 32'(out_result_a), 32'h0008);
        check("bp_first_in_ready", 32'(in_ready_a), 32'd1);
        in_dat = 4'd7;
        step();
        check("bp_full_in_ready", 32'(in_ready_a), 32'd0);
        check("bp_full_hold", 32'(out_result_a), 32'h0008);
        in_dat = 4'd9;
        step();
        check("bp_stall_in_ready", 32'(in_ready_a), 32'd0);
        check("bp_stall_hold", 32'(out_result_a), 32'h0008);
        check("bp_stall_valid", 32'(out_valid_a), 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_rel_second", 32'(out_result_a), 32'h0080);
        check("bp_rel_in_ready", 32'(in_ready_a), 32'd1);
        step();
        in_valid_a = 1'b0;
        check("bp_rel_third", 32'(out_result_a), 32'h0200);
        check("bp_rel_third_valid", 32'(out_valid_a), 32'd1);
        step();
        check("bp_drained", 32'(out_valid_a), 32'd0);

`ifdef BINARY_ONEHOT_THERM_EN
        // ---- thermometer mode ----
        in_therm   = 1'b1;
        in_valid_a = 1'b1;
        in_dat     = 4'd3;
        step();
        check("therm3_result", 32'(out_result_a), 32'h000F);
        in_dat = 4'd15;
        step();
        check("therm15_result", 32'(out_result_a), 32'hFFFF);
        check("therm15_err", 32'(out_err_a), 32'd0);
        in_valid_a = 1'b0;
        in_valid_b = 1'b1;
        in_dat     = 4'd12;
        step();
        check("therm_oor_result", 32'(out_result_b), 32'h03FF);
        check("therm_oor_err", 32'(out_err_b), 32'd1);
        in_therm = 1'b0;
        in_dat   = 4'd4;
        step();
        in_valid_b = 1'b0;
        check("therm_off_result", 32'(out_result_b), 32'h0010);
        step();
`endif

        // ---- reset while FULL ----
        out_ready  = 1'b0;
        in_valid_a = 1'b1;
        in_dat     = 4'd1;
        step();
        in_dat = 4'd2;
        step();
        in_valid_a = 1'b0;
        check("pre_rst_full", 32'(in_ready_a), 32'd0);
        check("pre_rst_err_cnt_nz", 32'(err_cnt_b != 8'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid_a), 32'd0);
        check("async_rst_in_ready", 32'(in_ready_a), 32'd1);
        check("async_rst_err_cnt", 32'(err_cnt_b), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("post_rst_no_beat", 32'(out_valid_a), 32'd0);
        check("post_rst_result", 32'(out_result_a), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
